// File: rtl/tlb_refill_walker_pkg.sv
// Shared constants and state encoding for the TLB refill walker.
package tlb_refill_walker_pkg;

  localparam int unsigned VADDR_W        = 32;
  localparam int unsigned PTE_W          = 32;
  localparam int unsigned OFFSET         = 12;
  localparam int unsigned PHYS_ADDR_SIZE = 32;
  localparam int unsigned VPN_W          = VADDR_W - OFFSET;
  localparam int unsigned PTE_VALID_BIT  = 0;
  localparam int unsigned PTE_BYTES      = 4;
  localparam int unsigned PTE_SHIFT      = $clog2(PTE_BYTES);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_WRITE  = 3'd2,
    ST_SETTLE = 3'd3,
    ST_FAULT  = 3'd4
  } walk_state_e;

endpackage : tlb_refill_walker_pkg

// File: rtl/tlb_refill_walker_pte_address_gen.sv
// PTE address generator: ptbr + VPN * PTE_BYTES, summed at full width and
// truncated to the physical address width (wraps silently).
module pte_address_gen
  import tlb_refill_walker_pkg::*;
(
  input  logic [PHYS_ADDR_SIZE-1:0] ptbr,
  input  logic [VPN_W-1:0]          vpn,
  output logic [PHYS_ADDR_SIZE-1:0] pte_addr_c
);

  localparam int unsigned IDX_W = VPN_W + PTE_SHIFT;
  localparam int unsigned SUM_W = ((PHYS_ADDR_SIZE > IDX_W) ? PHYS_ADDR_SIZE : IDX_W) + 1;

  logic [SUM_W-1:0] sum_full;
  logic             unused_carry;

  // Full-width add; bits above the physical width are discarded.
  assign sum_full     = SUM_W'(ptbr) + SUM_W'({vpn, {PTE_SHIFT{1'b0}}});
  assign pte_addr_c   = sum_full[PHYS_ADDR_SIZE-1:0];
  assign unused_carry = ^sum_full[SUM_W-1:PHYS_ADDR_SIZE];

endmodule : pte_address_gen

// File: rtl/tlb_refill_walker.sv
// TLB refill walker: on a TLB miss, fetches the PTE from a single-level
// linear page table and writes the translation back to the TLB.
// Optional feature macro: TLB_REFILL_FAULT_EN (invalid PTE -> held page fault
// until fault_ack_i; without it every PTE is written and page_fault_o is 0).
module tlb_refill_walker
  import tlb_refill_walker_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      tlb_miss_i,
  input  logic [VADDR_W-1:0]        miss_vaddr_i,
  input  logic [PHYS_ADDR_SIZE-1:0] ptbr_i,
  output logic                      mem_req_o,
  output logic [PHYS_ADDR_SIZE-1:0] mem_addr_o,
  input  logic                      mem_ready_i,
  input  logic [PTE_W-1:0]          mem_data_i,
  output logic [VPN_W-1:0]          w_virtual_page_o,
  output logic [VPN_W-1:0]          w_phys_page_o,
  output logic                      write_enable_o,
  output logic                      stall_o,
  output logic                      page_fault_o,
  input  logic                      fault_ack_i
);

  walk_state_e               state;
  logic [VPN_W-1:0]          vpn_q;
  logic [VPN_W-1:0]          miss_vpn;
  logic [PHYS_ADDR_SIZE-1:0] pte_addr_c;
  logic                      unused_bits;

  assign miss_vpn = miss_vaddr_i[VADDR_W-1:OFFSET];

  // Low bits never feed the walk; acknowledge them here to keep lint quiet.
  assign unused_bits = ^{miss_vaddr_i[OFFSET-1:0], mem_data_i[OFFSET-1:0], fault_ack_i};

  pte_address_gen u_pte_address_gen (
    .ptbr       (ptbr_i),
    .vpn        (miss_vpn),
    .pte_addr_c (pte_addr_c)
  );

`ifndef TLB_REFILL_FAULT_EN
  assign page_fault_o = 1'b0;
`endif

  // Walk FSM with registered outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state            <= ST_IDLE;
      vpn_q            <= '0;
      mem_req_o        <= 1'b0;
      mem_addr_o       <= '0;
      w_virtual_page_o <= '0;
      w_phys_page_o    <= '0;
      write_enable_o   <= 1'b0;
      stall_o          <= 1'b0;
`ifdef TLB_REFILL_FAULT_EN
      page_fault_o     <= 1'b0;
`endif
    end else begin
      write_enable_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (tlb_miss_i) begin
            vpn_q      <= miss_vpn;
            mem_addr_o <= pte_addr_c;
            mem_req_o  <= 1'b1;
            stall_o    <= 1'b1;
            state      <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem_ready_i) begin
            mem_req_o <= 1'b0;
`ifdef TLB_REFILL_FAULT_EN
            if (!mem_data_i[PTE_VALID_BIT]) begin
              page_fault_o <= 1'b1;
              state        <= ST_FAULT;
            end else begin
              w_virtual_page_o <= vpn_q;
              w_phys_page_o    <= mem_data_i[PTE_W-1:OFFSET];
              write_enable_o   <= 1'b1;
              state            <= ST_WRITE;
            end
`else
            w_virtual_page_o <= vpn_q;
            w_phys_page_o    <= mem_data_i[PTE_W-1:OFFSET];
            write_enable_o   <= 1'b1;
            state            <= ST_WRITE;
`endif
          end
        end
        ST_WRITE: begin
          state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          stall_o <= 1'b0;
          state   <= ST_IDLE;
        end
`ifdef TLB_REFILL_FAULT_EN
        ST_FAULT: begin
          if (fault_ack_i) begin
            page_fault_o <= 1'b0;
            stall_o      <= 1'b0;
            state        <= ST_IDLE;
          end
        end
`endif
        default: begin
          mem_req_o <= 1'b0;
          stall_o   <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : tlb_refill_walker

// File: tb/tb_tlb_refill_walker.sv
// Bench for tlb_refill_walker: directed vector table, hand sequences for
// reset/back-to-back corners, then randomized walks against a reference model.
module tb_tlb_refill_walker;
  import tlb_refill_walker_pkg::*;

`ifdef TLB_REFILL_FAULT_EN
  localparam bit FAULT_BUILD = 1'b1;
`else
  localparam bit FAULT_BUILD = 1'b0;
`endif

  logic                      clock;
  logic                      reset_n;
  logic                      tlb_miss_i;
  logic [VADDR_W-1:0]        miss_vaddr_i;
  logic [PHYS_ADDR_SIZE-1:0] ptbr_i;
  logic                      mem_req_o;
  logic [PHYS_ADDR_SIZE-1:0] mem_addr_o;
  logic                      mem_ready_i;
  logic [PTE_W-1:0]          mem_data_i;
  logic [VPN_W-1:0]          w_virtual_page_o;
  logic [VPN_W-1:0]          w_phys_page_o;
  logic                      write_enable_o;
  logic                      stall_o;
  logic                      page_fault_o;
  logic                      fault_ack_i;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] ptbr;
    logic [31:0] vaddr;
    logic [31:0] data;
    int          delay;
    logic [31:0] exp_addr;
    logic [19:0] exp_vpn;
    logic [19:0] exp_ppn;
    bit          invalid_pte;
  } vec_t;

  tlb_refill_walker dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .tlb_miss_i       (tlb_miss_i),
    .miss_vaddr_i     (miss_vaddr_i),
    .ptbr_i           (ptbr_i),
    .mem_req_o        (mem_req_o),
    .mem_addr_o       (mem_addr_o),
    .mem_ready_i      (mem_ready_i),
    .mem_data_i       (mem_data_i),
    .w_virtual_page_o (w_virtual_page_o),
    .w_phys_page_o    (w_phys_page_o),
    .write_enable_o   (write_enable_o),
    .stall_o          (stall_o),
    .page_fault_o     (page_fault_o),
    .fault_ack_i      (fault_ack_i)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: translation contents computed from the page-table rules.
  function automatic vec_t model(input logic [31:0] ptbr, input logic [31:0] vaddr,
                                 input logic [31:0] data, input int delay);
    vec_t v;
    longint unsigned vpn;
    longint unsigned sum;
    vpn           = longint'(vaddr) / 4096;
    sum           = longint'(ptbr) + vpn * 4;
    v.ptbr        = ptbr;
    v.vaddr       = vaddr;
    v.data        = data;
    v.delay       = delay;
    v.exp_addr    = 32'(sum % 64'h1_0000_0000);
    v.exp_vpn     = 20'(vpn);
    v.exp_ppn     = 20'(longint'(data) / 4096);
    v.invalid_pte = (data % 2) == 0;
    return v;
  endfunction

  // Noise on inputs the walker must ignore in its current state.
  task automatic jitter(input bit noise, input bit allow_ready, input logic [31:0] vaddr,
                        input logic [31:0] ptbr);
    if (noise) begin
      tlb_miss_i   = 1'($urandom);
      miss_vaddr_i = $urandom;
      ptbr_i       = $urandom;
      fault_ack_i  = FAULT_BUILD ? 1'b0 : 1'($urandom);
      if (allow_ready) mem_ready_i = 1'($urandom);
      mem_data_i   = $urandom;
    end else begin
      tlb_miss_i   = 1'b0;
      miss_vaddr_i = vaddr;
      ptbr_i       = ptbr;
      fault_ack_i  = 1'b0;
      if (allow_ready) mem_ready_i = 1'b0;
    end
  endtask

  task automatic do_walk(input vec_t v, input bit noise);
    bit fault;
    fault        = FAULT_BUILD && v.invalid_pte;
    ptbr_i       = v.ptbr;
    miss_vaddr_i = v.vaddr;
    tlb_miss_i   = 1'b1;
    mem_ready_i  = 1'b0;
    fault_ack_i  = 1'b0;
    tick();
    chk("req_start", 64'(mem_req_o), 64'd1);
    chk("stall_start", 64'(stall_o), 64'd1);
    chk("mem_addr", 64'(mem_addr_o), 64'(v.exp_addr));
    chk("we_idle", 64'(write_enable_o), 64'd0);
    for (int c = 0; c < v.delay; c++) begin
      jitter(noise, 1'b0, v.vaddr, v.ptbr);
      mem_ready_i = 1'b0;
      tick();
      chk("req_hold", 64'(mem_req_o), 64'd1);
      chk("addr_hold", 64'(mem_addr_o), 64'(v.exp_addr));
      chk("we_wait", 64'(write_enable_o), 64'd0);
    end
    jitter(noise, 1'b0, v.vaddr, v.ptbr);
    mem_ready_i = 1'b1;
    mem_data_i  = v.data;
    tick();
    jitter(noise, 1'b1, v.vaddr, v.ptbr);
    chk("req_drop", 64'(mem_req_o), 64'd0);
    chk("stall_resp", 64'(stall_o), 64'd1);
    if (fault) begin
      chk("pf_set", 64'(page_fault_o), 64'd1);
      chk("we_fault", 64'(write_enable_o), 64'd0);
      fault_ack_i = 1'b0;
      for (int c = 0; c < 10; c++) begin
        tick();
        fault_ack_i = 1'b0;
        chk("pf_hold", 64'(page_fault_o), 64'd1);
        chk("stall_fault", 64'(stall_o), 64'd1);
        chk("we_fault_hold", 64'(write_enable_o), 64'd0);
      end
      fault_ack_i = 1'b1;
      tick();
      fault_ack_i = 1'b0;
      tlb_miss_i  = 1'b0;
      chk("pf_clear", 64'(page_fault_o), 64'd0);
      chk("stall_ack", 64'(stall_o), 64'd0);
    end else begin
      chk("we_pulse", 64'(write_enable_o), 64'd1);
      chk("w_vpn", 64'(w_virtual_page_o), 64'(v.exp_vpn));
      chk("w_ppn", 64'(w_phys_page_o), 64'(v.exp_ppn));
      chk("pf_zero", 64'(page_fault_o), 64'd0);
      tick();
      jitter(noise, 1'b1, v.vaddr, v.ptbr);
      chk("we_one_cycle", 64'(write_enable_o), 64'd0);
      chk("stall_settle", 64'(stall_o), 64'd1);
      chk("w_vpn_hold", 64'(w_virtual_page_o), 64'(v.exp_vpn));
      tick();
      tlb_miss_i  = 1'b0;
      mem_ready_i = 1'b0;
      fault_ack_i = 1'b0;
      chk("stall_done", 64'(stall_o), 64'd0);
      chk("we_done", 64'(write_enable_o), 64'd0);
    end
    mem_ready_i = 1'b0;
    tick();
    chk("idle_req", 64'(mem_req_o), 64'd0);
    chk("idle_stall", 64'(stall_o), 64'd0);
    chk("idle_we", 64'(write_enable_o), 64'd0);
    chk("idle_ppn_hold", 64'(w_phys_page_o), fault ? 64'(w_phys_page_o) : 64'(v.exp_ppn));
  endtask

  vec_t table_v[6];

  initial begin
    reset_n      = 1'b0;
    tlb_miss_i   = 1'b0;
    miss_vaddr_i = '0;
    ptbr_i       = '0;
    mem_ready_i  = 1'b0;
    mem_data_i   = '0;
    fault_ack_i  = 1'b0;

    table_v[0] = '{32'h0001_0000, 32'h0000_3ABC, 32'h0004_5001, 0, 32'h0001_000C, 20'h00003, 20'h00045, 1'b0};
    table_v[1] = '{32'h0001_0000, 32'h0000_3ABC, 32'h0004_5001, 5, 32'h0001_000C, 20'h00003, 20'h00045, 1'b0};
    table_v[2] = '{32'hFFFF_FFF0, 32'h0000_5000, 32'h1234_5001, 1, 32'h0000_0004, 20'h00005, 20'h12345, 1'b0};
    table_v[3] = '{32'h0001_0000, 32'h0000_3ABC, 32'h0004_5000, 2, 32'h0001_000C, 20'h00003, 20'h00045, 1'b1};
    table_v[4] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_F001, 3, 32'h803F_FFFC, 20'hFFFFF, 20'hFFFFF, 1'b0};
    table_v[5] = '{32'h0000_0000, 32'h0000_0FFF, 32'h0000_1001, 0, 32'h0000_0000, 20'h00000, 20'h00001, 1'b0};

    tick();
    tick();
    chk("rst_req", 64'(mem_req_o), 64'd0);
    chk("rst_addr", 64'(mem_addr_o), 64'd0);
    chk("rst_stall", 64'(stall_o), 64'd0);
    chk("rst_we", 64'(write_enable_o), 64'd0);
    chk("rst_vpn", 64'(w_virtual_page_o), 64'd0);
    chk("rst_ppn", 64'(w_phys_page_o), 64'd0);
    chk("rst_pf", 64'(page_fault_o), 64'd0);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) do_walk(table_v[i], 1'b0);

    // Reset while waiting in REQ aborts the walk without a write.
    ptbr_i       = 32'h0002_0000;
    miss_vaddr_i = 32'h0000_7000;
    tlb_miss_i   = 1'b1;
    tick();
    tlb_miss_i = 1'b0;
    chk("abort_req_before", 64'(mem_req_o), 64'd1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("abort_req", 64'(mem_req_o), 64'd0);
    chk("abort_stall", 64'(stall_o), 64'd0);
    chk("abort_we", 64'(write_enable_o), 64'd0);
    mem_ready_i = 1'b1;
    mem_data_i  = 32'h0009_9001;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("abort_no_we", 64'(write_enable_o), 64'd0);
      chk("abort_no_stall", 64'(stall_o), 64'd0);
      chk("abort_ppn", 64'(w_phys_page_o), 64'd0);
    end
    mem_ready_i = 1'b0;

    // Persistent miss: a new walk starts after SETTLE returns to IDLE.
    ptbr_i       = 32'h0001_0000;
    miss_vaddr_i = 32'h0000_3ABC;
    mem_data_i   = 32'h0004_5001;
    mem_ready_i  = 1'b1;
    tlb_miss_i   = 1'b1;
    tick();
    chk("bb_req", 64'(mem_req_o), 64'd1);
    tick();
    chk("bb_we1", 64'(write_enable_o), 64'd1);
    tick();
    chk("bb_settle", 64'(stall_o), 64'd1);
    tick();
    chk("bb_idle", 64'(stall_o), 64'd0);
    tick();
    chk("bb_restart", 64'(stall_o), 64'd1);
    chk("bb_restart_req", 64'(mem_req_o), 64'd1);
    tlb_miss_i = 1'b0;
    tick();
    chk("bb_we2", 64'(write_enable_o), 64'd1);
    mem_ready_i = 1'b0;
    tick();
    tick();
    chk("bb_end", 64'(stall_o), 64'd0);

    for (int i = 0; i < 30; i++) begin
      vec_t v;
      v = model($urandom & 32'hFFFF_FFFC, $urandom, $urandom, int'($urandom_range(0, 6)));
      do_walk(v, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_tlb_refill_walker
